// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo: 8N1 serial receiver feeding a byte FIFO, Z80 I/O mapped.   |
// | Optional 8E1 parity check when UART_RX_PARITY_EN is defined.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int CLK_HZ     = 25000000,
  parameter int BAUD       = 9600,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       rd_stb,
  input  logic       wr_stb,
  input  logic       rs,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq_n
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PAR   = 3'd3,
`endif
    S_STOP  = 3'd4
  } state_t;

  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  tick_cnt_q <= '0;
    else if (tick) tick_cnt_q <= '0;
    else           tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  logic sync1_q, sync2_q, rxd_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
    end
  end

  assign rxd_s = sync2_q;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;

  // Data/parity/stop counters wrap 15->0 naturally, so only the sample point is decoded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == 4'd7) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            shift_q <= {rxd_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == 3'd7) state_q <= S_PAR;
`else
            if (bit_q == 3'd7) state_q <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PAR: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= S_STOP;
        end
`endif
        S_STOP: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic stop_hit, push, fe_set, pe_flag;

  assign stop_hit = tick && (state_q == S_STOP) && (cnt_q == 4'd15);
  assign push     = stop_hit && rxd_s;
  assign fe_set   = stop_hit && !rxd_s;

  logic [7:0]          mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wptr_q, rptr_q;
  logic                ovr_q, fe_q, ie_q, irq_n_q;
  logic                empty, full, pop, ctrl_wr, flush, push_ok, irq_pend;
  logic                unused_data;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                    (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign pop      = rd_stb && rs && !empty;
  assign ctrl_wr  = wr_stb && !rs;
  assign flush    = ctrl_wr && data_in[0];
  assign push_ok  = push && (!full || pop);
  assign irq_pend = ie_q && (!empty || ovr_q || fe_q || pe_flag);
  assign unused_data = ^data_in[6:1];

`ifdef UART_RX_PARITY_EN
  logic pe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   pe_q <= 1'b0;
    else if (flush) pe_q <= 1'b0;
    else if (tick && (state_q == S_PAR) && (cnt_q == 4'd15) && (rxd_s != ^shift_q))
      pe_q <= 1'b1;
  end

  assign pe_flag = pe_q;
`else
  assign pe_flag = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wptr_q[DEPTH_LOG2-1:0]] <= shift_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      ie_q    <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      irq_n_q <= ~irq_pend;
      if (ctrl_wr) ie_q <= data_in[7];
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
        ovr_q  <= 1'b0;
        fe_q   <= 1'b0;
      end else begin
        if (pop)              rptr_q <= rptr_q + PTR_ONE;
        if (push_ok)          wptr_q <= wptr_q + PTR_ONE;
        if (push && !push_ok) ovr_q  <= 1'b1;
        if (fe_set)           fe_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out = {irq_pend, 2'b00, pe_flag, fe_q, ovr_q, full, !empty};
    if (rs) data_out = empty ? 8'h00 : mem_q[rptr_q[DEPTH_LOG2-1:0]];
  end

  assign irq_n = irq_n_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Testbench for uart_rx_fifo: serial frames against a queue-based receiver model.
module tb_uart_rx_fifo;

  localparam int CLK_HZ   = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT_CLKS = 160;
  localparam int DEPTH    = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_stb = 1'b0;
  logic       wr_stb = 1'b0;
  logic       rs = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       irq_n;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic m_ovr = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_ie = 1'b0;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rd_stb(rd_stb), .wr_stb(wr_stb),
    .rs(rs), .data_in(data_in), .data_out(data_out), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  function automatic logic model_cause();
    return (mq.size() != 0) || m_ovr || m_fe || m_pe;
  endfunction

  function automatic logic [7:0] exp_status();
    return {m_ie && model_cause(), 2'b00, m_pe, m_fe, m_ovr,
            mq.size() == DEPTH, mq.size() != 0};
  endfunction

  function automatic logic [7:0] model_pop();
    if (mq.size() == 0) return 8'h00;
    return mq.pop_front();
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ie = 1'b0;
  endfunction

  function automatic void model_write(input logic sel, input logic [7:0] v);
    if (!sel) begin
      if (v[0]) begin
        mq.delete();
        m_ovr = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
      end
      m_ie = v[7];
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT_CLKS) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PARITY) drive_bit((^b) ^ par_flip);
    drive_bit(stop);
    rxd = 1'b1;
    if (stop) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    if (PARITY && par_flip) m_pe = 1'b1;
  endtask

  task automatic read_reg(input logic sel, output logic [7:0] v);
    @(negedge clk);
    rs = sel; rd_stb = 1'b1;
    #1 v = data_out;
    @(negedge clk);
    rd_stb = 1'b0; rs = 1'b0;
  endtask

  task automatic write_reg(input logic sel, input logic [7:0] v);
    @(negedge clk);
    rs = sel; wr_stb = 1'b1; data_in = v;
    @(negedge clk);
    wr_stb = 1'b0; rs = 1'b0; data_in = 8'h00;
    model_write(sel, v);
  endtask

  task automatic test_reset();
    model_reset();
    @(negedge clk);
    rs = 1'b0; #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_status: got %02h expected 00", data_out); end
    checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL reset_irq_n: got %b expected 1", irq_n); end
    rs = 1'b1; #1;
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", data_out); end
    rs = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] v, e;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL single_status: got %02h expected %02h", v, e); end
    e = model_pop(); read_reg(1'b1, v); checks++;
    if (v !== e) begin errors++; $display("FAIL single_data: got %02h expected %02h", v, e); end
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL single_status_after: got %02h expected %02h", v, e); end
  endtask

  task automatic test_overflow();
    logic [7:0] v, e;
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    idle(20);
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL ovf_status: got %02h expected %02h", v, e); end
    for (int i = 0; i < 17; i++) begin
      e = model_pop(); read_reg(1'b1, v); checks++;
      if (v !== e) begin errors++; $display("FAIL ovf_pop%0d: got %02h expected %02h", i, v, e); end
    end
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL ovf_status_after: got %02h expected %02h", v, e); end
    write_reg(1'b0, 8'h01);
  endtask

  task automatic test_irq();
    logic [7:0] v, e, b;
    b = 8'hA3;
    write_reg(1'b0, 8'h80);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PARITY) drive_bit(^b);
    rxd = 1'b1;
    repeat (70) @(posedge clk);
    #1 checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_early: got %b expected 1", irq_n); end
    repeat (30) @(posedge clk);
    #1 checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL irq_assert: got %b expected 0", irq_n); end
    mq.push_back(b);
    idle(60);
    e = model_pop(); read_reg(1'b1, v); checks++;
    if (v !== e) begin errors++; $display("FAIL irq_data: got %02h expected %02h", v, e); end
    checks++;
    if (irq_n !== 1'b0) begin errors++; $display("FAIL irq_hold: got %b expected 0", irq_n); end
    @(negedge clk); checks++;
    if (irq_n !== 1'b1) begin errors++; $display("FAIL irq_release: got %b expected 1", irq_n); end
    write_reg(1'b0, 8'h00);
  endtask

  task automatic test_frame_error();
    logic [7:0] v, e;
    send_frame(8'hC5, 1'b0, 1'b0);
    idle(320);
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL fe_status: got %02h expected %02h", v, e); end
    e = model_pop(); read_reg(1'b1, v); checks++;
    if (v !== e) begin errors++; $display("FAIL fe_data: got %02h expected %02h", v, e); end
    write_reg(1'b0, 8'h01);
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL fe_cleared: got %02h expected %02h", v, e); end
  endtask

  task automatic test_glitch();
    logic [7:0] v, e;
    rxd = 1'b0;
    idle(40);
    rxd = 1'b1;
    idle(300);
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL glitch_status: got %02h expected %02h", v, e); end
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    e = model_pop(); read_reg(1'b1, v); checks++;
    if (v !== e) begin errors++; $display("FAIL glitch_next_frame: got %02h expected %02h", v, e); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] v, e, b;
    send_frame(8'h11, 1'b1, 1'b0);
    b = 8'h99;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    reset_n = 1'b0;
    rxd = 1'b1;
    idle(5);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    #1 checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL midreset_status: got %02h expected 00", data_out); end
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL midreset_status2: got %02h expected %02h", v, e); end
    e = model_pop(); read_reg(1'b1, v); checks++;
    if (v !== e) begin errors++; $display("FAIL midreset_data: got %02h expected %02h", v, e); end
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL midreset_empty: got %02h expected %02h", v, e); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] v, e;
    send_frame(8'h01, 1'b1, 1'b1);
    idle(20);
    e = exp_status(); read_reg(1'b0, v); checks++;
    if (v !== e) begin errors++; $display("FAIL par_status: got %02h expected %02h", v, e); end
    e = model_pop(); read_reg(1'b1, v); checks++;
    if (v !== e) begin errors++; $display("FAIL par_data: got %02h expected %02h", v, e); end
    write_reg(1'b0, 8'h01);
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] v, e, b;
    logic stop, pf;
    int nf, nops, kind;
    for (int g = 0; g < 8; g++) begin
      nf = $urandom_range(1, 3);
      for (int f = 0; f < nf; f++) begin
        b    = 8'($urandom);
        stop = ($urandom_range(0, 7) != 0);
        pf   = ($urandom_range(0, 3) == 0);
        send_frame(b, stop, pf);
        if (!stop) idle(320);
      end
      idle(20);
      nops = $urandom_range(1, 5);
      for (int k = 0; k < nops; k++) begin
        @(negedge clk); checks++;
        if (irq_n !== ~(m_ie && model_cause())) begin
          errors++;
          $display("FAIL rnd_irq_n g%0d: got %b expected %b", g, irq_n, ~(m_ie && model_cause()));
        end
        kind = $urandom_range(0, 9);
        if (kind <= 5) begin
          e = model_pop(); read_reg(1'b1, v); checks++;
          if (v !== e) begin errors++; $display("FAIL rnd_data g%0d: got %02h expected %02h", g, v, e); end
        end else if (kind <= 7) begin
          e = exp_status(); read_reg(1'b0, v); checks++;
          if (v !== e) begin errors++; $display("FAIL rnd_status g%0d: got %02h expected %02h", g, v, e); end
        end else if (kind == 8) begin
          v = 8'($urandom) & 8'h80;
          if ($urandom_range(0, 2) == 0) v[0] = 1'b1;
          write_reg(1'b0, v);
        end else begin
          write_reg(1'b1, 8'($urandom));
        end
      end
    end
    write_reg(1'b0, 8'h01);
  endtask

  initial begin
    rxd = 1'b1;
    reset_n = 1'b0;
    idle(5);
    @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_single();
    test_overflow();
    test_irq();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
